// File: rtl/traffic_car_sensor_pkg.sv
// Shared state encoding and sizing helper for the car-sensor channels.
package traffic_car_sensor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_SERVE = 2'd2
  } chan_state_e;

  // Bits needed to hold values 0..max_val (max_val >= 1).
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/traffic_car_sensor_channel.sv
// One detector channel: synchroniser, debounce, request FSM with single-deep
// pending car, and wrapping served counter.
module traffic_car_sensor_channel
  import traffic_car_sensor_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MIN_GREEN       = 8,
  parameter int CNT_W           = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             det_raw,
  input  logic             lite,
  output logic             car,
  output logic             served,
  output logic [CNT_W-1:0] count
);

  localparam int DW = cnt_width(DEBOUNCE_CYCLES);
  localparam int GW = cnt_width(MIN_GREEN);
  localparam logic [DW-1:0] DEB_MAX    = DW'(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [GW-1:0] GREEN_LAST = GW'(MIN_GREEN - 1);

  logic             sync1_q, sync2_q;
  logic [DW-1:0]    deb_cnt_q, deb_cnt_d;
  logic             det_q, det_d;
  chan_state_e      state_q, state_d;
  logic             pend_q, pend_d;
  logic [GW-1:0]    gcnt_q, gcnt_d;
  logic             served_q, served_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             retire;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      deb_cnt_q <= '0;
      det_q     <= 1'b0;
      pend_q    <= 1'b0;
      gcnt_q    <= '0;
      served_q  <= 1'b0;
      count_q   <= '0;
    end else begin
      sync1_q   <= det_raw;
      sync2_q   <= sync1_q;
      deb_cnt_q <= deb_cnt_d;
      det_q     <= det_d;
      pend_q    <= pend_d;
      gcnt_q    <= gcnt_d;
      served_q  <= served_d;
      count_q   <= count_d;
    end
  end

  // Counter saturates so a stuck-high detector produces only one det pulse.
  always_comb begin
    deb_cnt_d = deb_cnt_q;
    if (!sync2_q) begin
      deb_cnt_d = '0;
    end else if (deb_cnt_q != DEB_MAX) begin
      deb_cnt_d = deb_cnt_q + DW'(1);
    end
    det_d = sync2_q && (deb_cnt_q == DEB_LAST);
  end

  assign retire = (state_q == ST_SERVE) && lite && (gcnt_q >= GREEN_LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (det_q) state_d = ST_WAIT;
      ST_WAIT:  if (lite) state_d = ST_SERVE;
      ST_SERVE: begin
        if (retire) begin
          state_d = (pend_q || det_q) ? ST_WAIT : ST_IDLE;
        end else if (!lite) begin
          state_d = ST_WAIT;
        end
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    gcnt_d   = gcnt_q;
    pend_d   = pend_q;
    served_d = 1'b0;
    count_d  = count_q;
    case (state_q)
      ST_WAIT: if (lite) gcnt_d = GW'(1);
      ST_SERVE: begin
        if (retire) begin
          gcnt_d   = '0;
          pend_d   = 1'b0;
          served_d = 1'b1;
          count_d  = count_q + CNT_W'(1);
        end else begin
          // A partial green is discarded; the car keeps waiting.
          gcnt_d = lite ? gcnt_q + GW'(1) : '0;
          if (det_q) pend_d = 1'b1;
        end
      end
      default: begin
        gcnt_d = '0;
        pend_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    car    = (state_q != ST_IDLE);
    served = served_q;
    count  = count_q;
  end

endmodule

// File: rtl/traffic_car_sensor.sv
// Two independent car-sensor channels (EW, NS) plus the sticky light-conflict flag.
module traffic_car_sensor
  import traffic_car_sensor_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MIN_GREEN       = 8,
  parameter int CNT_W           = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ew_det_raw,
  input  logic             ns_det_raw,
  input  logic             EWLite,
  input  logic             NSLite,
  output logic             EWCar,
  output logic             NSCar,
  output logic             ew_served,
  output logic             ns_served,
  output logic [CNT_W-1:0] ew_count,
  output logic [CNT_W-1:0] ns_count,
  output logic             lite_err
);

  logic [1:0]       raw_vec, lite_vec, car_vec, served_vec;
  logic [CNT_W-1:0] count_arr [2];
  logic             lite_err_q, lite_err_d;

  assign raw_vec  = {ns_det_raw, ew_det_raw};
  assign lite_vec = {NSLite, EWLite};

  // Index 0 is EW, index 1 is NS.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
      traffic_car_sensor_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .MIN_GREEN      (MIN_GREEN),
        .CNT_W          (CNT_W)
      ) u_chan (
        .clock  (clock),
        .reset_n(reset_n),
        .det_raw(raw_vec[gi]),
        .lite   (lite_vec[gi]),
        .car    (car_vec[gi]),
        .served (served_vec[gi]),
        .count  (count_arr[gi])
      );
    end
  endgenerate

  always_comb begin
    lite_err_d = lite_err_q | (EWLite == NSLite);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lite_err_q <= 1'b0;
    end else begin
      lite_err_q <= lite_err_d;
    end
  end

  assign EWCar     = car_vec[0];
  assign NSCar     = car_vec[1];
  assign ew_served = served_vec[0];
  assign ns_served = served_vec[1];
  assign ew_count  = count_arr[0];
  assign ns_count  = count_arr[1];
  assign lite_err  = lite_err_q;

endmodule

// File: tb/tb_traffic_car_sensor.sv
// Directed scenarios plus randomized traffic checked against a request-count model.
module tb_traffic_car_sensor;

  localparam int D  = 4;
  localparam int MG = 8;
  localparam int CW = 8;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic ew_det_raw = 1'b0, ns_det_raw = 1'b0;
  logic EWLite = 1'b0, NSLite = 1'b0;
  logic EWCar, NSCar, ew_served, ns_served, lite_err;
  logic [CW-1:0] ew_count, ns_count;

  int errors = 0;
  int checks = 0;

  traffic_car_sensor #(.DEBOUNCE_CYCLES(D), .MIN_GREEN(MG), .CNT_W(CW)) dut (
    .clock(clock), .reset_n(reset_n),
    .ew_det_raw(ew_det_raw), .ns_det_raw(ns_det_raw),
    .EWLite(EWLite), .NSLite(NSLite),
    .EWCar(EWCar), .NSCar(NSCar),
    .ew_served(ew_served), .ns_served(ns_served),
    .ew_count(ew_count), .ns_count(ns_count),
    .lite_err(lite_err)
  );

  always #5 clock = ~clock;

  wire [2*CW+4:0] act_vec = {EWCar, NSCar, ew_served, ns_served, ew_count, ns_count, lite_err};

  // Reference model: outstanding requests per channel (0 none, 1 one car, 2 one plus pending)
  // and the length of the current green streak while serving.
  bit            m_r1 [2], m_r2 [2], m_det [2], m_served [2], m_err;
  int            m_run [2], m_out [2], m_streak [2];
  logic [CW-1:0] m_cnt [2];

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_r1[c] = 0; m_r2[c] = 0; m_det[c] = 0; m_served[c] = 0;
      m_run[c] = 0; m_out[c] = 0; m_streak[c] = 0; m_cnt[c] = '0;
    end
    m_err = 0;
  endtask

  task automatic model_edge();
    bit raw [2];
    bit light [2];
    raw[0] = ew_det_raw; raw[1] = ns_det_raw;
    light[0] = EWLite;   light[1] = NSLite;
    for (int c = 0; c < 2; c++) begin
      m_served[c] = 0;
      if (m_out[c] == 0) begin
        if (m_det[c]) m_out[c] = 1;
      end else if (m_streak[c] == 0) begin
        if (light[c]) m_streak[c] = 1;
      end else if (light[c]) begin
        m_streak[c] = m_streak[c] + 1;
        if (m_streak[c] >= MG) begin
          m_served[c] = 1;
          m_cnt[c]    = m_cnt[c] + 1'b1;
          m_out[c]    = (m_out[c] == 2 || m_det[c]) ? 1 : 0;
          m_streak[c] = 0;
        end else if (m_det[c]) begin
          m_out[c] = 2;
        end
      end else begin
        m_streak[c] = 0;
        if (m_det[c]) m_out[c] = 2;
      end
      m_run[c] = m_r2[c] ? m_run[c] + 1 : 0;
      m_det[c] = (m_run[c] == D);
      m_r2[c]  = m_r1[c];
      m_r1[c]  = raw[c];
    end
    if (light[0] == light[1]) m_err = 1;
  endtask

  function automatic logic [2*CW+4:0] exp_vec();
    return {m_out[0] > 0, m_out[1] > 0, m_served[0], m_served[1], m_cnt[0], m_cnt[1], m_err};
  endfunction

  task automatic tick();
    @(posedge clock);
    if (reset_n) model_edge();
    #1;
  endtask

  task automatic make_ew_car();
    ew_det_raw = 1'b0;
    repeat (3) tick();
    ew_det_raw = 1'b1;
    repeat (D + 3) tick();
    ew_det_raw = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      ew_det_raw = i[0];
      ns_det_raw = ~i[0];
      tick();
      checks++;
      if (act_vec !== '0) begin
        errors++;
        $display("FAIL reset_hold i=%0d got=%h want=0", i, act_vec);
      end
    end
    ew_det_raw = 1'b0; ns_det_raw = 1'b0;
    EWLite = 1'b0; NSLite = 1'b1;
    model_reset();
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (act_vec !== '0) begin
        errors++;
        $display("FAIL reset_release i=%0d got=%h want=0", i, act_vec);
      end
    end
  endtask

  task automatic test_glitch();
    ew_det_raw = 1'b1;
    repeat (3) tick();
    ew_det_raw = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if (EWCar !== 1'b0 || act_vec !== exp_vec()) begin
        errors++;
        $display("FAIL glitch i=%0d EWCar=%b vec=%h want EWCar=0 vec=%h", i, EWCar, act_vec, exp_vec());
      end
    end
  endtask

  task automatic test_latency();
    ew_det_raw = 1'b1;
    for (int i = 1; i <= D + 3; i++) begin
      tick();
      checks++;
      if (EWCar !== (i == D + 3)) begin
        errors++;
        $display("FAIL latency edge=%0d EWCar=%b want=%b", i, EWCar, (i == D + 3));
      end
    end
  endtask

  task automatic test_serve();
    EWLite = 1'b1; NSLite = 1'b0;
    for (int i = 1; i <= MG; i++) begin
      tick();
      checks++;
      if (ew_served !== (i == MG) || EWCar !== (i != MG)) begin
        errors++;
        $display("FAIL serve edge=%0d served=%b car=%b want served=%b car=%b",
                 i, ew_served, EWCar, (i == MG), (i != MG));
      end
    end
    checks++;
    if (ew_count !== 8'd1) begin
      errors++;
      $display("FAIL serve_count got=%0d want=1", ew_count);
    end
    EWLite = 1'b0; NSLite = 1'b1; ew_det_raw = 1'b0;
  endtask

  task automatic test_partial_green();
    make_ew_car();
    EWLite = 1'b1; NSLite = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (ew_served !== 1'b0 || EWCar !== 1'b1) begin
        errors++;
        $display("FAIL partial_green i=%0d served=%b car=%b want served=0 car=1", i, ew_served, EWCar);
      end
    end
    EWLite = 1'b0; NSLite = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (EWCar !== 1'b1) begin
        errors++;
        $display("FAIL partial_red i=%0d car=%b want=1", i, EWCar);
      end
    end
    EWLite = 1'b1; NSLite = 1'b0;
    for (int i = 1; i <= MG; i++) begin
      tick();
      checks++;
      if (ew_served !== (i == MG) || EWCar !== (i != MG)) begin
        errors++;
        $display("FAIL partial_fresh edge=%0d served=%b car=%b want served=%b car=%b",
                 i, ew_served, EWCar, (i == MG), (i != MG));
      end
    end
    checks++;
    if (ew_count !== 8'd2) begin
      errors++;
      $display("FAIL partial_count got=%0d want=2", ew_count);
    end
    EWLite = 1'b0; NSLite = 1'b1;
  endtask

  task automatic test_back_to_back();
    make_ew_car();
    EWLite = 1'b1; NSLite = 1'b0;
    ew_det_raw = 1'b1;
    for (int i = 1; i <= 2 * MG; i++) begin
      tick();
      if (i == D) ew_det_raw = 1'b0;
      checks++;
      if (ew_served !== (i == MG || i == 2 * MG) || EWCar !== (i != 2 * MG)) begin
        errors++;
        $display("FAIL back_to_back edge=%0d served=%b car=%b want served=%b car=%b",
                 i, ew_served, EWCar, (i == MG || i == 2 * MG), (i != 2 * MG));
      end
    end
    checks++;
    if (ew_count !== 8'd4) begin
      errors++;
      $display("FAIL back_to_back_count got=%0d want=4", ew_count);
    end
    EWLite = 1'b0; NSLite = 1'b1;
  endtask

  task automatic test_lite_err_async_reset();
    EWLite = 1'b1; NSLite = 1'b1;
    tick();
    checks++;
    if (lite_err !== 1'b1) begin
      errors++;
      $display("FAIL lite_err_set got=%b want=1", lite_err);
    end
    EWLite = 1'b0; NSLite = 1'b1;
    repeat (3) tick();
    checks++;
    if (lite_err !== 1'b1) begin
      errors++;
      $display("FAIL lite_err_sticky got=%b want=1", lite_err);
    end
    make_ew_car();
    EWLite = 1'b1; NSLite = 1'b0;
    repeat (3) tick();
    checks++;
    if (EWCar !== 1'b1 || act_vec !== exp_vec()) begin
      errors++;
      $display("FAIL pre_reset_serve car=%b vec=%h want car=1 vec=%h", EWCar, act_vec, exp_vec());
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (act_vec !== '0) begin
      errors++;
      $display("FAIL async_reset got=%h want=0", act_vec);
    end
    model_reset();
    tick();
    EWLite = 1'b0; NSLite = 1'b1;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (act_vec !== '0) begin
        errors++;
        $display("FAIL post_reset i=%0d got=%h want=0", i, act_vec);
      end
    end
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if ($urandom_range(0, 5) == 0) ew_det_raw = ~ew_det_raw;
      if ($urandom_range(0, 5) == 0) ns_det_raw = ~ns_det_raw;
      if ($urandom_range(0, 11) == 0) EWLite = ~EWLite;
      NSLite = ~EWLite;
      if ($urandom_range(0, 299) == 0) NSLite = EWLite;
      tick();
      checks++;
      if (act_vec !== exp_vec()) begin
        errors++;
        $display("FAIL random cyc=%0d got=%h want=%h", cyc, act_vec, exp_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_glitch();
    test_latency();
    test_serve();
    test_partial_green();
    test_back_to_back();
    test_lite_err_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
